regfile_port_arbiter: RTL and testbench

//  Shares the single-port 16x20 register file between two requesters: A = core pipeline, B = loader/debug.

---
 rtl/regfile_port_arbiter_pkg.sv | 18 +
 rtl/regfile_port_arbiter_if.sv | 16 +
 rtl/regfile_port_arbiter_rr_arbiter2.sv | 23 ++
 rtl/regfile_port_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: FSM encodings,
// requester ids and the WAIT counter preload helper.
package regfile_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // WAIT counts down to zero, so it is preloaded with latency-1.
  function automatic logic [1:0] wait_init(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side handshake bundle: one instance per requester (A, B).
interface regfile_port_arbiter_if #(
  parameter int DW = 20,
  parameter int AW = 4
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arbiter2
  import regfile_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt,
  output logic       o_any
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last_gnt == REQ_B) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  assign o_any = |i_req;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a single-port register file between requesters A and B: arbitrates,
// latches the winning request, sequences rf_wr/rf_rd and returns read data.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DW         = 20,
  parameter int AW         = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_port_arbiter_if.slave  a,
  regfile_port_arbiter_if.slave  b,
  output logic [DW-1:0]          rf_in_data,
  output logic [AW-1:0]          rf_address,
  output logic                   rf_wr,
  output logic                   rf_rd,
  input  logic [DW-1:0]          rf_out_data,
  output logic                   busy
);

  localparam logic [1:0] LAT_INIT = wait_init(RD_LATENCY);

  logic [1:0]    r_state;
  logic          r_last_gnt;
  logic          r_id;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_cnt;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic          r_a_rvalid;
  logic          r_b_rvalid;

  logic [1:0]    w_gnt;
  logic          w_any;
  logic          w_win_id;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  logic          w_ack_phase;

  rr_arbiter2 u_arb (
    .i_req      ({b.req, a.req}),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt),
    .o_any      (w_any)
  );

  assign w_win_id    = w_gnt[1] ? REQ_B : REQ_A;
  assign w_win_we    = w_gnt[1] ? b.we    : a.we;
  assign w_win_addr  = w_gnt[1] ? b.addr  : a.addr;
  assign w_win_wdata = w_gnt[1] ? b.wdata : a.wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= REQ_B;
      r_id       <= REQ_A;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id       <= w_win_id;
            r_last_gnt <= w_win_id;
            r_addr     <= w_win_addr;
            r_wdata    <= w_win_wdata;
            r_state    <= w_win_we ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: r_state <= ST_IDLE;
        ST_READ: begin
          r_cnt   <= LAT_INIT;
          r_state <= ST_WAIT;
        end
        default: begin
          // Final WAIT edge: read data is valid now, hand it to the issuer.
          if (r_cnt == 2'd0) begin
            if (r_id == REQ_A) begin
              r_a_rdata  <= rf_out_data;
              r_a_rvalid <= 1'b1;
            end else begin
              r_b_rdata  <= rf_out_data;
              r_b_rvalid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
      endcase
    end
  end

  assign rf_wr       = (r_state == ST_WRITE);
  assign rf_rd       = (r_state == ST_READ);
  assign busy        = (r_state != ST_IDLE);
  assign w_ack_phase = rf_wr | rf_rd;
  assign rf_address  = r_addr;
  assign rf_in_data  = r_wdata;

  assign a.ack    = w_ack_phase && (r_id == REQ_A);
  assign b.ack    = w_ack_phase && (r_id == REQ_B);
  assign a.rvalid = r_a_rvalid;
  assign b.rvalid = r_b_rvalid;
  assign a.rdata  = r_a_rdata;
  assign b.rdata  = r_b_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 16x20 register file.
module tb_regfile_port_arbiter;

  localparam int DW = 20;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  regfile_port_arbiter_if #(.DW(DW), .AW(AW)) a_if ();
  regfile_port_arbiter_if #(.DW(DW), .AW(AW)) b_if ();

  logic [DW-1:0] rf_in_data;
  logic [DW-1:0] rf_out_data;
  logic [AW-1:0] rf_address;
  logic          rf_wr;
  logic          rf_rd;
  logic          busy;

  regfile_port_arbiter #(.DW(DW), .AW(AW), .RD_LATENCY(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a_if),
    .b           (b_if),
    .rf_in_data  (rf_in_data),
    .rf_address  (rf_address),
    .rf_wr       (rf_wr),
    .rf_rd       (rf_rd),
    .rf_out_data (rf_out_data),
    .busy        (busy)
  );

  logic [DW-1:0] mem [16];
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = '0;
    rf_out_data = '0;
  end
  always @(posedge clk) begin
    if (rf_wr) mem[rf_address] <= rf_in_data;
    if (rf_rd) rf_out_data <= mem[rf_address];
  end

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset) check("strobe_excl", 32'(rf_wr & rf_rd), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic req, input logic we,
                       input logic [3:0] addr, input logic [19:0] wdata);
    if (id == 1'b0) begin
      a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    end else begin
      b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input logic id);
    return id ? b_if.ack : a_if.ack;
  endfunction
  function automatic logic rvalid_of(input logic id);
    return id ? b_if.rvalid : a_if.rvalid;
  endfunction
  function automatic logic [19:0] rdata_of(input logic id);
    return id ? b_if.rdata : a_if.rdata;
  endfunction

  task automatic txn(input string nm, input logic id, input logic we,
                     input logic [3:0] addr, input logic [19:0] wdata, input logic [19:0] exp);
    int waited;
    drive(id, 1'b1, we, addr, wdata);
    step();
    waited = 1;
    while (!ack_of(id) && waited < 8) begin
      step();
      waited++;
    end
    check({nm, "_ack_lat"}, 32'(waited), 32'd1);
    check({nm, "_wr"}, 32'(rf_wr), 32'(we));
    check({nm, "_rd"}, 32'(rf_rd), 32'(!we));
    check({nm, "_addr"}, 32'(rf_address), 32'(addr));
    if (we) check({nm, "_wdata"}, 32'(rf_in_data), 32'(wdata));
    drive(id, 1'b0, we, addr, wdata);
    step();
    if (!we) begin
      check({nm, "_wait_rvalid"}, 32'(rvalid_of(id)), 32'd0);
      check({nm, "_wait_busy"}, 32'(busy), 32'd1);
      step();
      check({nm, "_rvalid"}, 32'(rvalid_of(id)), 32'd1);
      check({nm, "_rdata"}, 32'(rdata_of(id)), 32'(exp));
      check({nm, "_rv_busy"}, 32'(busy), 32'd0);
      step();
      check({nm, "_rvalid_end"}, 32'(rvalid_of(id)), 32'd0);
    end else begin
      check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    logic        id;
    logic        we;
    logic [3:0]  addr;
    logic [19:0] wdata;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [19:0] b2b_data(input int i);
    return 20'(32'h80000 + i * 32'h1111);
  endfunction

  initial begin
    int cyc, last_ack, waited;

    vecs[0] = '{1'b0, 1'b1, 4'h1, 20'h00001, 20'h00000};
    vecs[1] = '{1'b0, 1'b0, 4'h1, 20'h00000, 20'h00001};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 20'hABCDE, 20'h00000};
    vecs[3] = '{1'b1, 1'b1, 4'hF, 20'hFFFFF, 20'h00000};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 20'h00000, 20'hFFFFF};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 20'h00000, 20'hABCDE};
    vecs[6] = '{1'b0, 1'b1, 4'h7, 20'h5A5A5, 20'h00000};
    vecs[7] = '{1'b1, 1'b0, 4'h7, 20'h00000, 20'h5A5A5};

    drive(1'b0, 1'b0, 1'b0, 4'h0, 20'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 20'h0);

    // Reset and idle
    reset = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(rf_wr), 32'd0);
    check("rst_rd", 32'(rf_rd), 32'd0);
    check("rst_addr", 32'(rf_address), 32'd0);
    check("rst_indata", 32'(rf_in_data), 32'd0);
    check("rst_acks", 32'({a_if.ack, b_if.ack, a_if.rvalid, b_if.rvalid}), 32'd0);
    check("rst_rdata", 32'(a_if.rdata | b_if.rdata), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_strobes", 32'({rf_wr, rf_rd}), 32'd0);
    end

    // Table of single-requester transactions
    for (int k = 0; k < 8; k++)
      txn($sformatf("vec%0d", k), vecs[k].id, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp);
    check("a_rdata_hold", 32'(a_if.rdata), 32'h0ABCDE);

    // Tie with last_gnt = B: A first, then B
    drive(1'b0, 1'b1, 1'b1, 4'h2, 20'h22222);
    drive(1'b1, 1'b1, 1'b1, 4'h3, 20'h33333);
    step();
    check("rr1_a_ack", 32'(a_if.ack), 32'd1);
    check("rr1_b_ack", 32'(b_if.ack), 32'd0);
    check("rr1_addr", 32'(rf_address), 32'h2);
    drive(1'b0, 1'b0, 1'b1, 4'h2, 20'h22222);
    step();
    check("rr1_gap", 32'({a_if.ack, b_if.ack, busy}), 32'd0);
    step();
    check("rr1_b_ack2", 32'(b_if.ack), 32'd1);
    check("rr1_b_addr", 32'(rf_address), 32'h3);
    check("rr1_b_data", 32'(rf_in_data), 32'h33333);
    drive(1'b1, 1'b0, 1'b1, 4'h3, 20'h33333);
    step();
    txn("rr_a_solo", 1'b0, 1'b1, 4'h4, 20'h44444, 20'h0);

    // Tie with last_gnt = A: B first
    drive(1'b0, 1'b1, 1'b1, 4'h5, 20'h55555);
    drive(1'b1, 1'b1, 1'b1, 4'h6, 20'h66666);
    step();
    check("rr2_b_ack", 32'(b_if.ack), 32'd1);
    check("rr2_a_ack", 32'(a_if.ack), 32'd0);
    check("rr2_addr", 32'(rf_address), 32'h6);
    drive(1'b1, 1'b0, 1'b1, 4'h6, 20'h66666);
    step();
    check("rr2_gap", 32'(busy), 32'd0);
    step();
    check("rr2_a_ack2", 32'(a_if.ack), 32'd1);
    check("rr2_a_addr", 32'(rf_address), 32'h5);
    drive(1'b0, 1'b0, 1'b1, 4'h5, 20'h55555);
    step();

    // B reads addr 0 while A holds a write to addr 0
    drive(1'b1, 1'b1, 1'b0, 4'h0, 20'h0);
    drive(1'b0, 1'b1, 1'b1, 4'h0, 20'h12345);
    step();
    check("rw_b_ack", 32'(b_if.ack), 32'd1);
    check("rw_rd", 32'(rf_rd), 32'd1);
    check("rw_a_ack", 32'(a_if.ack), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 20'h0);
    step();
    check("rw_wait", 32'({busy, rf_wr, rf_rd, a_if.ack}), 32'b1000);
    step();
    check("rw_b_rvalid", 32'(b_if.rvalid), 32'd1);
    check("rw_b_rdata", 32'(b_if.rdata), 32'hABCDE);
    step();
    check("rw_a_ack2", 32'(a_if.ack), 32'd1);
    check("rw_a_wr", 32'(rf_wr), 32'd1);
    check("rw_a_data", 32'(rf_in_data), 32'h12345);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 20'h12345);
    step();
    txn("rw_a_rd0", 1'b0, 1'b0, 4'h0, 20'h0, 20'h12345);
    check("rw_b_hold", 32'(b_if.rdata), 32'hABCDE);

    // Reset during WAIT of an A read
    drive(1'b0, 1'b1, 1'b0, 4'hF, 20'h0);
    step();
    check("ab_ack", 32'(a_if.ack), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'hF, 20'h0);
    step();
    check("ab_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("ab_async", 32'({busy, rf_wr, rf_rd, a_if.rvalid}), 32'd0);
    check("ab_rdata", 32'(a_if.rdata), 32'd0);
    check("ab_addr", 32'(rf_address), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("ab_held", 32'({busy, rf_wr, rf_rd, a_if.rvalid}), 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ab_after", 32'({busy, rf_wr, rf_rd, a_if.rvalid}), 32'd0);
      check("ab_after_rdata", 32'(a_if.rdata), 32'd0);
    end

    // Back-to-back A writes to every address, then read all back
    cyc = 0;
    last_ack = 0;
    drive(1'b0, 1'b1, 1'b1, 4'h0, b2b_data(0));
    for (int i = 0; i < 16; i++) begin
      waited = 0;
      do begin
        step();
        cyc++;
        waited++;
      end while (!a_if.ack && waited < 8);
      check("b2b_ack", 32'(a_if.ack), 32'd1);
      check("b2b_addr", 32'(rf_address), 32'(i));
      check("b2b_data", 32'(rf_in_data), 32'(b2b_data(i)));
      if (i > 0) check("b2b_gap", 32'(cyc - last_ack), 32'd2);
      last_ack = cyc;
      if (i < 15) drive(1'b0, 1'b1, 1'b1, 4'(i + 1), b2b_data(i + 1));
      else drive(1'b0, 1'b0, 1'b1, 4'h0, 20'h0);
    end
    step();
    for (int i = 0; i < 16; i++)
      txn($sformatf("b2b_rd%0d", i), 1'b0, 1'b0, 4'(i), 20'h0, b2b_data(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
